// File: rtl/qpsk_frame_pkg.sv
// Shared encodings for the sync + PN frame generator.
// Modes, FSM states, symbol constants and Barker sync words.
package qpsk_frame_pkg;

    typedef enum logic [1:0] {
        MODE_LEGACY = 2'b00,
        MODE_QPSK   = 2'b01,
        MODE_ONES   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SYNC    = 2'b01,
        ST_PAYLOAD = 2'b10
    } state_e;

    localparam logic [1:0] SYM_ONE  = 2'b11;
    localparam logic [1:0] SYM_ZERO = 2'b01;
    localparam logic [1:0] SYM_NONE = 2'b00;

    localparam logic [6:0]  BARKER7  = 7'h72;
    localparam logic [10:0] BARKER11 = 11'h712;
    localparam logic [12:0] BARKER13 = 13'h1F35;

    // Reserved mode behaves exactly like legacy.
    function automatic mode_e mode_decode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_LEGACY : mode_e'(m);
    endfunction

endpackage

// File: rtl/sync_pn_frame_gen_pn_lfsr.sv
// Fibonacci right-shift PN generator with single and double stepping.
// bit_a is the current output bit, bit_b the one after it.
module pn_lfsr #(
    parameter int          PN_DEG  = 10,
    parameter logic [15:0] PN_TAPS = 16'h0081,
    parameter logic [15:0] PN_SEED = 16'h0001
) (
    input  logic clk_fs,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  logic double_step,
    output logic bit_a,
    output logic bit_b
);

    localparam logic [PN_DEG-1:0] TAPS = PN_TAPS[PN_DEG-1:0];
    localparam logic [PN_DEG-1:0] SEED = PN_SEED[PN_DEG-1:0];

    logic [PN_DEG-1:0] state;
    logic [PN_DEG-1:0] nxt1;
    logic [PN_DEG-1:0] nxt2;

    function automatic logic [PN_DEG-1:0] adv(input logic [PN_DEG-1:0] s);
        return {^(s & TAPS), s[PN_DEG-1:1]};
    endfunction

    // One- and two-step lookahead of the register.
    always_comb begin
        nxt1 = adv(state);
        nxt2 = adv(nxt1);
    end

    assign bit_a = state[0];
    assign bit_b = nxt1[0];

    // Reseed has priority over stepping.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (double_step) begin
            state <= nxt2;
        end else if (step) begin
            state <= nxt1;
        end
    end

endmodule

// File: rtl/sync_pn_frame_gen.sv
// Framed symbol source: sync word followed by PN payload.
// Symbols advance once per DIV clocks; en low parks in IDLE.
module sync_pn_frame_gen
    import qpsk_frame_pkg::*;
#(
    parameter int          SYNC_LEN    = 13,
    parameter logic [15:0] SYNC_WORD   = 16'h1F35,
    parameter int          PN_DEG      = 10,
    parameter logic [15:0] PN_TAPS     = 16'h0081,
    parameter logic [15:0] PN_SEED     = 16'h0001,
    parameter int          PAYLOAD_LEN = 1023,
    parameter int          DIV         = 2
) (
    input  logic       clk_fs,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    output logic [1:0] sync_flag,
    output logic       frame_start
);

    localparam int FRAME_LEN = SYNC_LEN + PAYLOAD_LEN;
    localparam int SYM_W     = $clog2(FRAME_LEN + 1);
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SYM_W-1:0] SYNC_LAST = SYM_W'(SYNC_LEN - 1);
    localparam logic [SYM_W-1:0] FRM_LAST  = SYM_W'(FRAME_LEN - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    state_e           state, state_d;
    logic [SYM_W-1:0] sym_idx, idx_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       sym_d, flag_d;
    logic             valid_d, fs_d;
    logic             sync_bit;
    logic             lfsr_load, lfsr_step, lfsr_dbl;
    logic             pn_a, pn_b;

    assign tick = en && (div_cnt == DIV_LAST);

    // Symbol-rate divider, parked at zero while disabled.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Sync word is sent MSB-first starting at bit SYNC_LEN-1.
    always_comb begin
        sync_bit = SYNC_WORD[4'(SYNC_LEN - 1 - int'(sym_idx))];
    end

    pn_lfsr #(
        .PN_DEG  (PN_DEG),
        .PN_TAPS (PN_TAPS),
        .PN_SEED (PN_SEED)
    ) u_lfsr (
        .clk_fs      (clk_fs),
        .rst         (rst),
        .load        (lfsr_load),
        .step        (lfsr_step),
        .double_step (lfsr_dbl),
        .bit_a       (pn_a),
        .bit_b       (pn_b)
    );

    // Next-state, symbol selection and LFSR control.
    always_comb begin
        state_d   = state;
        idx_d     = sym_idx;
        mode_d    = mode_q;
        sym_d     = sym_out;
        flag_d    = sync_flag;
        valid_d   = 1'b0;
        fs_d      = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        lfsr_dbl  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            sym_d   = SYM_NONE;
            flag_d  = SYM_NONE;
        end else if (tick) begin
            valid_d = 1'b1;
            idx_d   = (sym_idx == FRM_LAST) ? '0 : sym_idx + 1'b1;
            unique case (state)
                ST_PAYLOAD: begin
                    flag_d  = SYM_NONE;
                    state_d = (sym_idx == FRM_LAST) ? ST_SYNC : ST_PAYLOAD;
                    unique case (mode_q)
                        MODE_QPSK: begin
                            sym_d    = {pn_a, pn_b};
                            lfsr_dbl = 1'b1;
                        end
                        MODE_ONES: begin
                            sym_d = SYM_ONE;
                        end
                        default: begin
                            sym_d     = {pn_a, 1'b1};
                            lfsr_step = 1'b1;
                        end
                    endcase
                end
                default: begin
                    sym_d   = sync_bit ? SYM_ONE : SYM_ZERO;
                    flag_d  = sym_d;
                    state_d = (sym_idx == SYNC_LAST) ? ST_PAYLOAD : ST_SYNC;
                    if (sym_idx == '0) begin
                        fs_d      = 1'b1;
                        lfsr_load = 1'b1;
                        mode_d    = mode_decode(mode);
                    end
                end
            endcase
        end
    end

    // FSM, frame position and latched mode.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sym_idx <= '0;
            mode_q  <= MODE_LEGACY;
        end else begin
            state   <= state_d;
            sym_idx <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Registered symbol outputs and strobes.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            sym_out     <= SYM_NONE;
            sync_flag   <= SYM_NONE;
            sym_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sym_out     <= sym_d;
            sync_flag   <= flag_d;
            sym_valid   <= valid_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_sync_pn_frame_gen.sv
// Directed bench for sync_pn_frame_gen: default build plus
// a DIV=1 / Barker-7 build for the asynchronous reset case.
module tb_sync_pn_frame_gen;

    logic       clk_fs = 1'b0;
    logic       rst, en, rst1, en1;
    logic [1:0] mode, mode1;
    logic [1:0] sym_out, sync_flag, sym_out1, sync_flag1;
    logic       sym_valid, frame_start, sym_valid1, frame_start1;
    logic [5:0] obs, obs1;
    logic       pn [0:2099];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fs_cyc = 0;
    logic [12:0] sw13 = 13'h1F35;
    logic [6:0]  sw7 = 7'h72;

    always #5 clk_fs = ~clk_fs;

    always @(posedge clk_fs) cyc <= cyc + 1;

    assign obs  = {sym_out, sync_flag, sym_valid, frame_start};
    assign obs1 = {sym_out1, sync_flag1, sym_valid1, frame_start1};

    sync_pn_frame_gen u0 (
        .clk_fs      (clk_fs),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .sym_out     (sym_out),
        .sym_valid   (sym_valid),
        .sync_flag   (sync_flag),
        .frame_start (frame_start)
    );

    sync_pn_frame_gen #(
        .SYNC_LEN    (7),
        .SYNC_WORD   (16'h0072),
        .PAYLOAD_LEN (5),
        .DIV         (1)
    ) u1 (
        .clk_fs      (clk_fs),
        .rst         (rst1),
        .en          (en1),
        .mode        (mode1),
        .sym_out     (sym_out1),
        .sym_valid   (sym_valid1),
        .sync_flag   (sync_flag1),
        .frame_start (frame_start1)
    );

    task automatic clk_step();
        @(posedge clk_fs);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        en = 1'b1; en1 = 1'b1;
        mode = 2'b00; mode1 = 2'b00;
        repeat (3) clk_step();
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want %b", obs, 6'b0);
        end
        n_tests++;
        if (obs1 !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs_u1 got %b want %b", obs1, 6'b0);
        end
    endtask

    task automatic test_sync();
        logic [1:0] e;
        rst = 1'b0;
        for (int s = 0; s < 13; s++) begin
            clk_step();
            n_tests++;
            if (sym_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sync_gap%0d got %b want 0", s, sym_valid);
            end
            clk_step();
            if (s == 0) fs_cyc = cyc;
            e = sw13[12-s] ? 2'b11 : 2'b01;
            n_tests++;
            if (obs !== {e, e, 1'b1, s == 0}) begin
                n_fail++;
                $display("FAIL sync_sym%0d got %b want %b", s, obs,
                         {e, e, 1'b1, s == 0});
            end
        end
    endtask

    task automatic test_payload_legacy();
        for (int p = 0; p < 1023; p++) begin
            repeat (2) clk_step();
            n_tests++;
            if (obs !== {pn[p], 1'b1, 2'b00, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL legacy_pay%0d got %b want %b", p, obs,
                         {pn[p], 1'b1, 2'b00, 1'b1, 1'b0});
            end
        end
        repeat (2) clk_step();
        n_tests++;
        if (obs !== 6'b111111) begin
            n_fail++;
            $display("FAIL frame2_start got %b want %b", obs, 6'b111111);
        end
        n_tests++;
        if (cyc - fs_cyc != 2072) begin
            n_fail++;
            $display("FAIL frame_period got %0d want 2072", cyc - fs_cyc);
        end
    endtask

    task automatic test_mode_change();
        logic [1:0] e;
        for (int s = 1; s < 13; s++) begin
            repeat (2) clk_step();
            e = sw13[12-s] ? 2'b11 : 2'b01;
            n_tests++;
            if (obs !== {e, e, 2'b10}) begin
                n_fail++;
                $display("FAIL f2_sync%0d got %b want %b", s, obs, {e, e, 2'b10});
            end
        end
        for (int p = 0; p < 1023; p++) begin
            if (p == 100) mode = 2'b10;
            repeat (2) clk_step();
            n_tests++;
            if (obs !== {pn[p], 1'b1, 2'b00, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL f2_pay%0d got %b want %b", p, obs,
                         {pn[p], 1'b1, 2'b00, 1'b1, 1'b0});
            end
        end
        for (int s = 0; s < 13; s++) begin
            repeat (2) clk_step();
            e = sw13[12-s] ? 2'b11 : 2'b01;
            n_tests++;
            if (obs !== {e, e, 1'b1, s == 0}) begin
                n_fail++;
                $display("FAIL f3_sync%0d got %b want %b", s, obs,
                         {e, e, 1'b1, s == 0});
            end
        end
        for (int p = 0; p < 1023; p++) begin
            if (p == 500) mode = 2'b01;
            repeat (2) clk_step();
            n_tests++;
            if (obs !== 6'b110010) begin
                n_fail++;
                $display("FAIL ones_pay%0d got %b want %b", p, obs, 6'b110010);
            end
        end
    endtask

    task automatic test_qpsk();
        logic [1:0] e;
        for (int s = 0; s < 13; s++) begin
            repeat (2) clk_step();
            e = sw13[12-s] ? 2'b11 : 2'b01;
            n_tests++;
            if (obs !== {e, e, 1'b1, s == 0}) begin
                n_fail++;
                $display("FAIL f4_sync%0d got %b want %b", s, obs,
                         {e, e, 1'b1, s == 0});
            end
        end
        for (int p = 0; p < 1023; p++) begin
            repeat (2) clk_step();
            n_tests++;
            if (obs !== {pn[2*p], pn[2*p+1], 2'b00, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL qpsk_pay%0d got %b want %b", p, obs,
                         {pn[2*p], pn[2*p+1], 2'b00, 1'b1, 1'b0});
            end
        end
        repeat (2) clk_step();
        n_tests++;
        if (obs !== 6'b111111) begin
            n_fail++;
            $display("FAIL f5_start got %b want %b", obs, 6'b111111);
        end
    endtask

    task automatic test_en_drop();
        logic [1:0] e;
        for (int s = 1; s < 13; s++) repeat (2) clk_step();
        for (int p = 0; p < 20; p++) repeat (2) clk_step();
        n_tests++;
        if (obs !== {pn[38], pn[39], 2'b00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pre_drop got %b want %b", obs,
                     {pn[38], pn[39], 2'b00, 1'b1, 1'b0});
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            n_tests++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("FAIL en_low%0d got %b want %b", k, obs, 6'b0);
            end
        end
        en = 1'b1;
        clk_step();
        n_tests++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reen_wait got %b want %b", obs, 6'b0);
        end
        for (int s = 0; s < 13; s++) begin
            if (s > 0) clk_step();
            clk_step();
            e = sw13[12-s] ? 2'b11 : 2'b01;
            n_tests++;
            if (obs !== {e, e, 1'b1, s == 0}) begin
                n_fail++;
                $display("FAIL reen_sync%0d got %b want %b", s, obs,
                         {e, e, 1'b1, s == 0});
            end
        end
        for (int p = 0; p < 2; p++) begin
            repeat (2) clk_step();
            n_tests++;
            if (obs !== {pn[2*p], pn[2*p+1], 2'b00, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reen_pay%0d got %b want %b", p, obs,
                         {pn[2*p], pn[2*p+1], 2'b00, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] e;
        rst1 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            clk_step();
            e = sw7[6-s] ? 2'b11 : 2'b01;
            n_tests++;
            if (obs1 !== {e, e, 1'b1, s == 0}) begin
                n_fail++;
                $display("FAIL u1_pre%0d got %b want %b", s, obs1,
                         {e, e, 1'b1, s == 0});
            end
        end
        #3 rst1 = 1'b1;
        #1;
        n_tests++;
        if (obs1 !== 6'b0) begin
            n_fail++;
            $display("FAIL u1_async_rst got %b want %b", obs1, 6'b0);
        end
        clk_step();
        clk_step();
        rst1 = 1'b0;
        for (int s = 0; s < 7; s++) begin
            clk_step();
            e = sw7[6-s] ? 2'b11 : 2'b01;
            n_tests++;
            if (obs1 !== {e, e, 1'b1, s == 0}) begin
                n_fail++;
                $display("FAIL u1_sync%0d got %b want %b", s, obs1,
                         {e, e, 1'b1, s == 0});
            end
        end
        for (int p = 0; p < 5; p++) begin
            clk_step();
            n_tests++;
            if (obs1 !== {pn[p], 1'b1, 2'b00, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL u1_pay%0d got %b want %b", p, obs1,
                         {pn[p], 1'b1, 2'b00, 1'b1, 1'b0});
            end
        end
        clk_step();
        n_tests++;
        if (obs1 !== 6'b111111) begin
            n_fail++;
            $display("FAIL u1_wrap got %b want %b", obs1, 6'b111111);
        end
    endtask

    initial begin
        // PN reference from the recurrence b[n+10] = b[n] ^ b[n+7], seed 1.
        for (int i = 0; i < 10; i++) pn[i] = (i == 0);
        for (int i = 10; i < 2100; i++) pn[i] = pn[i-10] ^ pn[i-3];
        test_reset();
        test_sync();
        test_payload_legacy();
        test_mode_change();
        test_qpsk();
        test_en_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
